channel_reduce_n: RTL and testbench
===================================

CHANNEL_REDUCE_N -- requirements
Module: channel_reduce_n

Interface
REQ-001 Parameter WIDTH, default 32, data width of both channels and the accumulator.
REQ-002 Parameter COUNT, default 4, elements per reduction; legal range 1..65535.
REQ-003 Parameter OP, default 0, reduction operator: 0 sum, 1 unsigned max, 2 unsigned min, 3 xor.
REQ-004 Parameter ONESHOT, default 1: 1 = one reduction then halt; 0 = repeat reductions indefinitely.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 in_out_data  input  WIDTH  element from the input channel, valid the cycle after an in_read_valid pulse.
REQ-008 in_read_ready  input  1  input channel has an element available.
REQ-009 in_write_ready  input  1  unused.
REQ-010 in_read_valid  output  1  one-cycle pop strobe to the input channel.
REQ-011 in_in_data / in_write_valid / in_rst  output  WIDTH/1/1  tied to 0.
REQ-012 out_out_data / out_read_ready  input  WIDTH/1  unused.
REQ-013 out_write_ready  input  1  output channel can accept a word.
REQ-014 out_in_data  output  WIDTH  reduction result; equals the accumulator at all times.
REQ-015 out_write_valid  output  1  one-cycle push strobe to the output channel.
REQ-016 out_read_valid / out_rst  output  1/1  tied to 0.
REQ-017 valid  output  1  result-complete indicator.
REQ-018 done_count  output  16  number of results pushed since reset; wraps modulo 2^16.

Function
REQ-019 The FSM SHALL use states RD_WAIT, RD_POP, RD_CAP, WR_WAIT, WR_PUSH and DONE.
REQ-020 RD_WAIT SHALL move to RD_POP on the first edge where in_read_ready=1, else hold.
REQ-021 RD_POP SHALL drive in_read_valid=1 for exactly one cycle, then move to RD_CAP unconditionally.
REQ-022 RD_CAP SHALL set acc <= OP(acc, in_out_data) and cnt <= cnt+1.
REQ-023 RD_CAP SHALL go to WR_WAIT if cnt+1==COUNT, else to RD_WAIT.
REQ-024 Sum SHALL wrap modulo 2^WIDTH with no carry kept; max/min SHALL compare unsigned.
REQ-025 Initial acc SHALL be 0 for sum/xor/max and all-ones for min.
REQ-026 WR_WAIT SHALL move to WR_PUSH on the first edge where out_write_ready=1, else hold.
REQ-027 WR_PUSH SHALL assert out_write_valid=1 and valid=1 for exactly one cycle, with out_in_data=acc.
REQ-028 WR_PUSH SHALL increment done_count.
REQ-029 After WR_PUSH with ONESHOT=1, the FSM SHALL enter DONE.
REQ-030 After WR_PUSH with ONESHOT=0, the FSM SHALL enter RD_WAIT with acc reinitialised and cnt=0 on the same edge.
REQ-031 DONE SHALL hold valid=1 and in_read_valid=out_write_valid=0 until reset; acc is frozen.
REQ-032 Latency: with ready inputs held at 1, element k SHALL be popped in cycle 3k+1, and the push SHALL occur in cycle 3*COUNT+1 after reset release (cycle 0 = first RD_WAIT cycle).
REQ-033 COUNT=1 SHALL go RD_CAP -> WR_WAIT after one element.
REQ-034 in_read_ready falling during RD_POP or RD_CAP SHALL NOT cancel the in-flight pop.
REQ-035 out_write_ready falling during WR_PUSH SHALL NOT cancel the push.
REQ-036 valid SHALL be 0 in all states other than WR_PUSH and DONE.

Reset
REQ-037 On rst=0, asynchronously: state=RD_WAIT, cnt=0, acc=initial value, done_count=0.
REQ-038 On rst=0, asynchronously: in_read_valid=out_write_valid=valid=0.
REQ-039 Reset mid-reduction SHALL discard partial accumulation; no push SHALL occur for the aborted reduction.
REQ-040 Deassertion SHALL take effect at the next rising edge; the first RD_WAIT evaluation occurs then.

Verification
REQ-041 OP=0, COUNT=4, inputs 1,2,3,4, both readies high -> single push of 10 in cycle 13; valid stays 1 afterwards; done_count=1.
REQ-042 OP=0, WIDTH=8, inputs 200,100 (COUNT=2) -> push 44 (wrap); OP=2, inputs 7,3,9 (COUNT=3) -> push 3.
REQ-043 ONESHOT=0, COUNT=2, inputs 5,6,7,8 -> pushes 11 then 15, each with a one-cycle valid pulse; done_count=2.
REQ-044 in_read_ready low for 5 cycles before element 2, then out_write_ready low for 3 cycles -> push delayed exactly 8 cycles; pops stay one-cycle strobes.
REQ-045 rst=0 asserted in RD_CAP after 2 of 4 elements -> outputs drop immediately; after release, 4 new elements 1,1,1,1 -> push 4.

Source files
------------

// File: rtl/channel_reduce_n.sv
// Pops COUNT words from an input channel, folds them with a fixed operator
// and pushes the result to an output channel; optionally repeats forever.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RD_WAIT | wait for the input channel to offer an element
// RD_POP  | one-cycle pop strobe to the input channel
// RD_CAP  | element is on in_out_data; fold it into the accumulator
// WR_WAIT | wait for the output channel to accept a word
// WR_PUSH | one-cycle push strobe, result on out_in_data
// DONE    | one-shot finished; valid held high until reset
module channel_reduce_n #(
  parameter int WIDTH   = 32,
  parameter int COUNT   = 4,
  parameter int OP      = 0,
  parameter int ONESHOT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_out_data,
  input  logic             in_read_ready,
  input  logic             in_write_ready,
  output logic             in_read_valid,
  output logic [WIDTH-1:0] in_in_data,
  output logic             in_write_valid,
  output logic             in_rst,
  input  logic [WIDTH-1:0] out_out_data,
  input  logic             out_read_ready,
  input  logic             out_write_ready,
  output logic [WIDTH-1:0] out_in_data,
  output logic             out_write_valid,
  output logic             out_read_valid,
  output logic             out_rst,
  output logic             valid,
  output logic [15:0]      done_count
);

  typedef enum logic [2:0] {
    RD_WAIT,
    RD_POP,
    RD_CAP,
    WR_WAIT,
    WR_PUSH,
    DONE
  } state_t;

  // min starts from all-ones so the first element always wins
  localparam logic [WIDTH-1:0] ACC_INIT = (OP == 2) ? {WIDTH{1'b1}} : '0;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [15:0]      done_q, done_d;
  logic [WIDTH-1:0] fold;
  logic             last_elem;
  logic             unused_inputs;

  assign unused_inputs = ^{in_write_ready, out_out_data, out_read_ready};

  assign in_in_data     = '0;
  assign in_write_valid = 1'b0;
  assign in_rst         = 1'b0;
  assign out_read_valid = 1'b0;
  assign out_rst        = 1'b0;
  assign out_in_data    = acc_q;
  assign done_count     = done_q;

  assign last_elem = (({1'b0, cnt_q} + 17'd1) == 17'(COUNT));

  always_comb begin
    case (OP)
      1:       fold = (in_out_data > acc_q) ? in_out_data : acc_q;
      2:       fold = (in_out_data < acc_q) ? in_out_data : acc_q;
      3:       fold = acc_q ^ in_out_data;
      default: fold = acc_q + in_out_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RD_WAIT;
      cnt_q   <= '0;
      acc_q   <= ACC_INIT;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    acc_d           = acc_q;
    done_d          = done_q;
    in_read_valid   = 1'b0;
    out_write_valid = 1'b0;
    valid           = 1'b0;
    case (state_q)
      RD_WAIT: begin
        if (in_read_ready) state_d = RD_POP;
      end
      RD_POP: begin
        in_read_valid = 1'b1;
        state_d       = RD_CAP;
      end
      RD_CAP: begin
        acc_d   = fold;
        cnt_d   = cnt_q + 16'd1;
        state_d = last_elem ? WR_WAIT : RD_WAIT;
      end
      WR_WAIT: begin
        if (out_write_ready) state_d = WR_PUSH;
      end
      WR_PUSH: begin
        out_write_valid = 1'b1;
        valid           = 1'b1;
        done_d          = done_q + 16'd1;
        if (ONESHOT != 0) begin
          state_d = DONE;
        end else begin
          state_d = RD_WAIT;
          acc_d   = ACC_INIT;
          cnt_d   = '0;
        end
      end
      DONE: begin
        valid = 1'b1;
      end
      default: state_d = RD_WAIT;
    endcase
  end

endmodule

// File: tb/tb_channel_reduce_n.sv
// Randomised bench for channel_reduce_n: one 32-bit sum, four 8-bit instances
// (one per operator) in lockstep, and a repeating COUNT=2 sum instance.
module tb_channel_reduce_n;

  localparam int PAT = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rd_rdy = 1'b0;
  logic wr_rdy = 1'b0;
  logic [31:0] din_m = '0;
  logic [31:0] din_r = '0;

  always #5 clk = ~clk;

  logic        m_irv, m_iwv, m_irst, m_owv, m_orv, m_orst, m_valid;
  logic [31:0] m_iid, m_oid;
  logic [15:0] m_dc;

  channel_reduce_n #(.WIDTH(32), .COUNT(4), .OP(0), .ONESHOT(1)) u_main (
    .clk(clk), .rst(rst),
    .in_out_data(din_m), .in_read_ready(rd_rdy), .in_write_ready(1'b0),
    .in_read_valid(m_irv), .in_in_data(m_iid), .in_write_valid(m_iwv), .in_rst(m_irst),
    .out_out_data(32'h0), .out_read_ready(1'b0), .out_write_ready(wr_rdy),
    .out_in_data(m_oid), .out_write_valid(m_owv), .out_read_valid(m_orv), .out_rst(m_orst),
    .valid(m_valid), .done_count(m_dc)
  );

  logic       op_irv [4];
  logic       op_owv [4];
  logic [7:0] op_oid [4];
  logic [7:0] unused_op_iid [4];
  logic       unused_op_iwv [4], unused_op_irst [4], unused_op_orv [4], unused_op_orst [4];
  logic       unused_op_valid [4];
  logic [15:0] unused_op_dc [4];

  for (genvar g = 0; g < 4; g++) begin : g_op
    channel_reduce_n #(.WIDTH(8), .COUNT(4), .OP(g), .ONESHOT(1)) u_op (
      .clk(clk), .rst(rst),
      .in_out_data(din_m[7:0]), .in_read_ready(rd_rdy), .in_write_ready(1'b0),
      .in_read_valid(op_irv[g]), .in_in_data(unused_op_iid[g]), .in_write_valid(unused_op_iwv[g]),
      .in_rst(unused_op_irst[g]),
      .out_out_data(8'h0), .out_read_ready(1'b0), .out_write_ready(wr_rdy),
      .out_in_data(op_oid[g]), .out_write_valid(op_owv[g]), .out_read_valid(unused_op_orv[g]),
      .out_rst(unused_op_orst[g]),
      .valid(unused_op_valid[g]), .done_count(unused_op_dc[g])
    );
  end

  logic        r_irv, r_owv, r_valid;
  logic [7:0]  r_oid;
  logic [15:0] r_dc;
  logic [7:0]  unused_r_iid;
  logic        unused_r_iwv, unused_r_irst, unused_r_orv, unused_r_orst;

  channel_reduce_n #(.WIDTH(8), .COUNT(2), .OP(0), .ONESHOT(0)) u_rep (
    .clk(clk), .rst(rst),
    .in_out_data(din_r[7:0]), .in_read_ready(rd_rdy), .in_write_ready(1'b0),
    .in_read_valid(r_irv), .in_in_data(unused_r_iid), .in_write_valid(unused_r_iwv), .in_rst(unused_r_irst),
    .out_out_data(8'h0), .out_read_ready(1'b0), .out_write_ready(wr_rdy),
    .out_in_data(r_oid), .out_write_valid(r_owv), .out_read_valid(unused_r_orv), .out_rst(unused_r_orst),
    .valid(r_valid), .done_count(r_dc)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  bit rd_pat [PAT];
  bit wr_pat [PAT];
  int edges = 0;

  logic [31:0] q_m[$], q_r[$], el_m[$], el_r[$];
  int          pop_m[$], pcyc_m[$], pcyc_r[$];
  logic [31:0] push_m[$];
  logic [7:0]  push_r[$];
  logic [7:0]  op_val [4];
  int          op_push [4];
  int          lock_bad = 0;
  int          valid_bad = 0;

  initial forever begin
    @(posedge clk);
    edges++;
    #1;
    if (edges < PAT) begin
      rd_rdy = rd_pat[edges];
      wr_rdy = wr_pat[edges];
    end else begin
      rd_rdy = 1'b1;
      wr_rdy = 1'b1;
    end
  end

  // input channels: element appears after the edge that ends the pop cycle
  initial forever begin
    @(negedge clk);
    if (rst && m_irv) begin
      @(posedge clk); #1;
      if (q_m.size() > 0) din_m = q_m.pop_front();
      else din_m = $urandom;
      @(posedge clk); #1;
      din_m = $urandom;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst && r_irv) begin
      @(posedge clk); #1;
      if (q_r.size() > 0) din_r = q_r.pop_front();
      else din_r = $urandom;
      @(posedge clk); #1;
      din_r = $urandom;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (m_irv) pop_m.push_back(edges);
      for (int g = 0; g < 4; g++) begin
        if (op_irv[g] !== m_irv || op_owv[g] !== m_owv) lock_bad++;
        if (op_owv[g]) op_push[g]++;
      end
      if (m_owv) begin
        push_m.push_back(m_oid);
        pcyc_m.push_back(edges);
        for (int g = 0; g < 4; g++) op_val[g] = op_oid[g];
        if (m_valid !== 1'b1) valid_bad++;
      end
      if (!m_owv && pcyc_m.size() == 0 && m_valid !== 1'b0) valid_bad++;
      if (r_owv) begin
        push_r.push_back(r_oid);
        pcyc_r.push_back(edges);
      end
      if (r_valid !== r_owv) valid_bad++;
    end
  end

  function automatic logic [31:0] reduce(input int op, input int w, input logic [31:0] e[$]);
    longint unsigned m, acc, v;
    m = (64'd1 << w) - 64'd1;
    acc = (op == 2) ? m : 64'd0;
    foreach (e[i]) begin
      v = {32'd0, e[i]} & m;
      case (op)
        0: acc = (acc + v) & m;
        1: if (v > acc) acc = v;
        2: if (v < acc) acc = v;
        default: acc = acc ^ v;
      endcase
    end
    return acc[31:0];
  endfunction

  // each element: wait for ready, then pop and capture cycles; then wait for write ready
  function automatic int push_time(input int start, input int n);
    int t;
    t = start;
    for (int k = 0; k < n; k++) begin
      while (!rd_pat[t] && t < PAT - 4) t++;
      t += 3;
    end
    while (!wr_pat[t] && t < PAT - 2) t++;
    return t + 1;
  endfunction

  task automatic begin_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    q_m.delete(); q_r.delete(); pop_m.delete(); pcyc_m.delete(); pcyc_r.delete();
    push_m.delete(); push_r.delete();
    for (int g = 0; g < 4; g++) begin op_push[g] = 0; op_val[g] = '0; end
    lock_bad = 0;
    valid_bad = 0;
  endtask

  task automatic set_ready(input int pct);
    for (int i = 0; i < PAT; i++) begin
      rd_pat[i] = ($urandom_range(0, 99) < pct);
      wr_pat[i] = ($urandom_range(0, 99) < pct);
    end
  endtask

  task automatic fill_rep(input int n);
    while (el_r.size() < n) el_r.push_back($urandom);
  endtask

  task automatic release_and_check(input string name);
    int t, ep, win, p, idx;
    int exp_pop[$];
    int exp_rc[$];
    logic [7:0] exp_rv[$];
    q_m = el_m;
    q_r = el_r;
    check({name, "/rst_pop"}, m_irv, 0);
    check({name, "/rst_push"}, m_owv, 0);
    check({name, "/rst_valid"}, m_valid, 0);
    check({name, "/rst_acc"}, m_oid, 0);
    check({name, "/rst_min_init"}, op_oid[2], 8'hFF);
    check({name, "/rst_rep_dc"}, r_dc, 0);
    t = 0;
    for (int k = 0; k < 4; k++) begin
      while (!rd_pat[t] && t < PAT - 4) t++;
      exp_pop.push_back(t + 1);
      t += 3;
    end
    while (!wr_pat[t] && t < PAT - 2) t++;
    ep = t + 1;
    win = ep + 6;
    t = 0;
    idx = 0;
    while (idx + 1 < el_r.size()) begin
      p = push_time(t, 2);
      if (p > win) break;
      exp_rv.push_back(8'((el_r[idx] + el_r[idx + 1]) & 32'hFF));
      exp_rc.push_back(p);
      idx += 2;
      t = p + 1;
    end
    edges = 0;
    rd_rdy = rd_pat[0];
    wr_rdy = wr_pat[0];
    rst = 1'b1;
    while (edges < win) @(negedge clk);

    check({name, "/push_count"}, push_m.size(), 1);
    if (push_m.size() > 0) begin
      check({name, "/push_val"}, push_m[0], reduce(0, 32, el_m));
      check({name, "/push_cycle"}, pcyc_m[0], ep);
    end
    check({name, "/pop_count"}, pop_m.size(), 4);
    for (int i = 0; i < 4 && i < pop_m.size(); i++)
      check($sformatf("%s/pop%0d_cycle", name, i), pop_m[i], exp_pop[i]);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s/op%0d_pushes", name, g), op_push[g], 1);
      check($sformatf("%s/op%0d_val", name, g), op_val[g], reduce(g, 8, el_m));
    end
    check({name, "/valid_held"}, m_valid, 1);
    check({name, "/done_no_push"}, m_owv, 0);
    check({name, "/done_no_pop"}, m_irv, 0);
    check({name, "/done_count"}, m_dc, 1);
    check({name, "/acc_frozen"}, m_oid, reduce(0, 32, el_m));
    check({name, "/ties"}, {m_iid, m_iwv, m_irst, m_orv, m_orst}, 0);
    check({name, "/rep_count"}, push_r.size(), exp_rv.size());
    for (int i = 0; i < push_r.size() && i < exp_rv.size(); i++) begin
      check($sformatf("%s/rep%0d_val", name, i), push_r[i], exp_rv[i]);
      check($sformatf("%s/rep%0d_cycle", name, i), pcyc_r[i], exp_rc[i]);
    end
    check({name, "/rep_dc"}, r_dc, exp_rv.size());
    check({name, "/lockstep"}, lock_bad, 0);
    check({name, "/valid_shape"}, valid_bad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] first2[$];

    set_ready(100);
    begin_reset();
    el_m = '{32'd1, 32'd2, 32'd3, 32'd4};
    el_r = '{32'd5, 32'd6, 32'd7, 32'd8};
    fill_rep(64);
    release_and_check("sum1234");

    begin_reset();
    el_m = '{32'd200, 32'd100, 32'd0, 32'd0};
    el_r.delete(); fill_rep(64);
    release_and_check("wrap");

    begin_reset();
    set_ready(100);
    for (int i = 6; i <= 10; i++) rd_pat[i] = 1'b0;
    for (int i = 17; i <= 19; i++) wr_pat[i] = 1'b0;
    el_m = '{32'd7, 32'd3, 32'd9, 32'd250};
    el_r.delete(); fill_rep(64);
    release_and_check("stall");
    if (pcyc_m.size() > 0) check("stall/delay8", pcyc_m[0], 21);

    begin_reset();
    set_ready(100);
    el_m = '{32'h1234_5678, 32'h0000_0F0F, 32'd9, 32'd9};
    el_r.delete(); fill_rep(64);
    q_m = el_m;
    q_r = el_r;
    edges = 0;
    rd_rdy = 1'b1;
    wr_rdy = 1'b1;
    rst = 1'b1;
    while (edges < 8) @(negedge clk);
    first2 = '{el_m[0], el_m[1]};
    check("abort/mid_acc", m_oid, reduce(0, 32, first2));
    check("abort/rep_dc_pre", r_dc, 1);
    rst = 1'b0;
    #1;
    check("abort/acc_cleared", m_oid, 0);
    check("abort/valid_low", m_valid, 0);
    check("abort/min_reinit", op_oid[2], 8'hFF);
    check("abort/rep_dc_cleared", r_dc, 0);
    begin_reset();
    el_m = '{32'd1, 32'd1, 32'd1, 32'd1};
    release_and_check("after_abort");

    for (int n = 0; n < 8; n++) begin
      begin_reset();
      set_ready(70);
      el_m.delete();
      for (int i = 0; i < 4; i++) el_m.push_back($urandom);
      el_r.delete(); fill_rep(64);
      release_and_check($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
